bus_rr_arbiter_wdt: RTL

Round-robin bus arbiter with a transfer-aware grant controller for the 4-master shared bus. It grants ownership one master at a time and never revokes a grant mid-transfer. It forces a hand-over once the owner exceeds a hold budget while others are waiting. An optional watchdog terminates transfers that a slave never completes. It sits beside the address decoder and master/slave muxes; its grants drive the master-select of the bus muxes.

---
 rtl/bus_rr_arbiter_wdt.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/bus_rr_arbiter_wdt.sv
// Round-robin grant controller for the 4-master shared bus with an owner hold budget.
// Define BUS_WDT_EN to add the transfer watchdog (TOUT state, wdt_ready_/wdt_err pulse).
module bus_rr_arbiter_wdt #(
   parameter int unsigned HOLD_MAX = 16,
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       m0_req_,
   input  logic       m1_req_,
   input  logic       m2_req_,
   input  logic       m3_req_,
   input  logic       bus_as_,
   input  logic       bus_ready_,
   output logic       m0_grnt_,
   output logic       m1_grnt_,
   output logic       m2_grnt_,
   output logic       m3_grnt_,
   output logic       wdt_ready_,
   output logic       wdt_err,
   output logic [1:0] owner
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_XFER
`ifdef BUS_WDT_EN
      , ST_TOUT
`endif
   } state_e;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

   state_e           state_q, state_d;
   logic [3:0]       grnt_q, grnt_d;
   logic [1:0]       owner_q, owner_d;
   logic [CNT_W-1:0] hold_q, hold_d;

   logic [3:0]       req;
   logic [3:0]       others;
   logic             others_wait;
   logic             owner_req;
   logic             busy;
   logic             hold_expired;
   logic [CNT_W-1:0] hold_inc;
   logic [1:0]       pick_any;
   logic [1:0]       pick_other;

`ifdef BUS_WDT_EN
   localparam logic [CNT_W-1:0] TOUT_LIM = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] tout_q, tout_d, tout_inc;
   logic             wdt_err_q, wdt_err_d;
   logic             wdt_ready_n_q, wdt_ready_n_d;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_ONE;
   endfunction

   // First requester after 'last' in wrap-around order; 'last' itself has lowest priority.
   function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] last);
      logic [1:0] idx;
      logic [1:0] win;
      win = last;
      for (int i = 4; i >= 1; i--) begin
         idx = last + 2'(i);
         if (mask[idx]) win = idx;
      end
      return win;
   endfunction

   always_comb begin
      // NOTE: every signal written here gets a default first so no path can infer a latch.
      state_d  = state_q;
      grnt_d   = grnt_q;
      owner_d  = owner_q;
      hold_d   = hold_q;
`ifdef BUS_WDT_EN
      tout_d        = tout_q;
      tout_inc      = sat_inc(tout_q);
      wdt_err_d     = 1'b0;
      wdt_ready_n_d = 1'b1;
`endif

      req          = ~{m3_req_, m2_req_, m1_req_, m0_req_};
      others       = req & ~(4'b0001 << owner_q);
      others_wait  = |others;
      owner_req    = req[owner_q];
      busy         = (state_q == ST_GRANT) || (state_q == ST_XFER);
      hold_inc     = sat_inc(hold_q);
      hold_expired = others_wait && (hold_inc >= HOLD_LIM);
      pick_any     = rr_pick(req, owner_q);
      pick_other   = rr_pick(others, owner_q);

      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               grnt_d  = 4'b0001 << pick_any;
               owner_d = pick_any;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // A starting transfer outranks release and hold expiry; as_ with ready_ completes at once.
            if (!bus_as_) begin
               if (bus_ready_) begin
                  state_d = ST_XFER;
`ifdef BUS_WDT_EN
                  tout_d  = '0;
`endif
               end
            end else if (!owner_req) begin
               if (others_wait) begin
                  grnt_d  = 4'b0001 << pick_other;
                  owner_d = pick_other;
               end else begin
                  grnt_d  = '0;
                  state_d = ST_IDLE;
               end
            end else if (hold_expired) begin
               grnt_d  = 4'b0001 << pick_other;
               owner_d = pick_other;
            end
         end
         ST_XFER: begin
            if (!bus_ready_) begin
               state_d = ST_GRANT;
            end
`ifdef BUS_WDT_EN
            else if (tout_inc >= TOUT_LIM) begin
               state_d       = ST_TOUT;
               grnt_d        = '0;
               wdt_err_d     = 1'b1;
               wdt_ready_n_d = 1'b0;
            end else begin
               tout_d = tout_inc;
            end
`endif
         end
`ifdef BUS_WDT_EN
         ST_TOUT: begin
            state_d = ST_IDLE;
         end
`endif
         default: begin
            state_d = ST_IDLE;
            grnt_d  = '0;
         end
      endcase

      // Hold budget restarts whenever the grant moves; it only runs while someone else waits.
      if (grnt_d != grnt_q) begin
         hold_d = '0;
      end else if (busy && others_wait) begin
         hold_d = hold_inc;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
      if (reset) begin
         state_q <= ST_IDLE;
         grnt_q  <= '0;
         owner_q <= 2'd3;
         hold_q  <= '0;
`ifdef BUS_WDT_EN
         tout_q        <= '0;
         wdt_err_q     <= 1'b0;
         wdt_ready_n_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         grnt_q  <= grnt_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
`ifdef BUS_WDT_EN
         tout_q        <= tout_d;
         wdt_err_q     <= wdt_err_d;
         wdt_ready_n_q <= wdt_ready_n_d;
`endif
      end
   end

   assign m0_grnt_ = ~grnt_q[0];
   assign m1_grnt_ = ~grnt_q[1];
   assign m2_grnt_ = ~grnt_q[2];
   assign m3_grnt_ = ~grnt_q[3];
   assign owner    = owner_q;

`ifdef BUS_WDT_EN
   assign wdt_ready_ = wdt_ready_n_q;
   assign wdt_err    = wdt_err_q;
`else
   assign wdt_ready_ = 1'b1;
   assign wdt_err    = 1'b0;
`endif

endmodule
